adder_ctrl_slave: RTL and testbench
===================================

ADDER_CTRL_SLAVE -- requirements
Module: adder_ctrl_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_BITS, default 6, AXI-Lite address width.
REQ-002 SHALL have parameter AXI_DATA_BITS, default 32, AXI-Lite data width; AXI_STRB_BITS = AXI_DATA_BITS/8.
REQ-003 SHALL have ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- s_axi_control_AWVALID/AWREADY/AWADDR  in/out/in  1/1/AXI_ADDR_BITS  write address channel
- s_axi_control_WVALID/WREADY/WDATA/WSTRB  in/out/in/in  1/1/AXI_DATA_BITS/AXI_STRB_BITS  write data channel
- s_axi_control_BVALID/BREADY/BRESP  out/in/out  1/1/2  write response
- s_axi_control_ARVALID/ARREADY/ARADDR  in/out/in  1/1/AXI_ADDR_BITS  read address
- s_axi_control_RVALID/RREADY/RDATA/RRESP  out/in/out/out  1/1/AXI_DATA_BITS/2  read data
- ap_start  out  1  level, kernel start
- ap_done  in  1  one-cycle pulse, kernel finished
- ap_idle  in  1  kernel idle level
- arg_a, arg_b  out  AXI_DATA_BITS  kernel operands
- result  in  AXI_DATA_BITS  kernel result
- result_vld  in  1  one-cycle strobe qualifying result

Function
REQ-004 Register map (byte offsets, ADDR compared in full): 0x00 CTRL, 0x10 ARG_A (RW), 0x18 ARG_B (RW), 0x20 RESULT (RO).
REQ-005 CTRL bits: [0] ap_start RW-set-only, [1] ap_done RO clear-on-read, [2] ap_idle RO live input, others read 0.
REQ-006 Write FSM states W_IDLE, W_DATA, W_RESP; W_IDLE->W_DATA on AWVALID&AWREADY (address latched); W_DATA->W_RESP on WVALID&WREADY (register updated that edge); W_RESP->W_IDLE on BVALID&BREADY.
REQ-007 AWREADY = (wstate==W_IDLE); WREADY = (wstate==W_DATA); BVALID = (wstate==W_RESP); BRESP always 2'b00.
REQ-008 Read FSM states R_IDLE, R_DATA; R_IDLE->R_DATA on ARVALID&ARREADY, RDATA registered that edge; R_DATA->R_IDLE on RVALID&RREADY.
REQ-009 ARREADY = (rstate==R_IDLE); RVALID = (rstate==R_DATA); RRESP always 2'b00; RDATA held stable while RVALID.
REQ-010 Read and write FSMs independent; concurrent read and write both proceed.
REQ-011 Writes to ARG_A/ARG_B apply WSTRB per byte; unmapped or RO writes ignored, still acknowledged OKAY.
REQ-012 Unmapped reads return 0, OKAY.
REQ-013 ap_start register set by CTRL write with WSTRB[0]=1 and WDATA[0]=1; writing 0 does not clear it.
REQ-014 ap_start cleared on edge where ap_done=1; set and clear same edge -> set wins (ap_start=1).
REQ-015 done_r set on ap_done=1; CTRL read returns done_r|ap_done at AR handshake edge, and done_r becomes 0 after that edge even if ap_done coincides.
REQ-016 RESULT register loads result on result_vld=1; read coincident with load returns old value.
REQ-017 arg_a, arg_b drive ARG_A, ARG_B registers directly; ap_start drives start register directly.

Reset
REQ-018 On reset=0, asynchronously: wstate=W_IDLE, rstate=R_IDLE, ap_start=0, done_r=0, ARG_A=ARG_B=RESULT=0, RDATA=0, latched addresses 0.
REQ-019 Hence during and after reset: BVALID=0, RVALID=0, AWREADY=1, ARREADY=1, WREADY=0.
REQ-020 Reset mid-transaction SHALL abandon it with no register update and no response issued.

Verification
REQ-021 Write 0x10 data 0x00000005 strb 0xF, write 0x18 0x00000007 -> arg_a=5, arg_b=7, one BVALID per write, BRESP=0.
REQ-022 Write 0x10 0xAABBCCDD strb 0xF then 0x11223344 strb 0x5 -> arg_a=0xAA22CC44.
REQ-023 Write CTRL 0x1 -> ap_start=1 next cycle; drive ap_done pulse -> ap_start=0 next edge; read CTRL -> bit1=1; read CTRL again -> bit1=0.
REQ-024 ap_done pulse and CTRL-write start=1 same edge -> ap_start stays 1, done_r=1.
REQ-025 result_vld with result 0x0000000C, read 0x20 -> RDATA=0xC; read 0x3C -> RDATA=0; hold RREADY=0 5 cycles -> RVALID and RDATA stable.
REQ-026 Assert reset=0 while wstate=W_DATA -> BVALID=0, target register unchanged, AWREADY=1 after release.

Source files
------------

// File: rtl/adder_ctrl_slave.sv
// AXI-Lite control slave for a simple two-operand kernel: holds the operand
// registers, exposes ap_start/ap_done/ap_idle handshakes and captures the result.
module adder_ctrl_slave #(
    parameter  int AXI_ADDR_BITS = 6,
    parameter  int AXI_DATA_BITS = 32,
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     s_axi_control_AWVALID,
    output logic                     s_axi_control_AWREADY,
    input  logic [AXI_ADDR_BITS-1:0] s_axi_control_AWADDR,
    input  logic                     s_axi_control_WVALID,
    output logic                     s_axi_control_WREADY,
    input  logic [AXI_DATA_BITS-1:0] s_axi_control_WDATA,
    input  logic [AXI_STRB_BITS-1:0] s_axi_control_WSTRB,
    output logic                     s_axi_control_BVALID,
    input  logic                     s_axi_control_BREADY,
    output logic [1:0]               s_axi_control_BRESP,
    input  logic                     s_axi_control_ARVALID,
    output logic                     s_axi_control_ARREADY,
    input  logic [AXI_ADDR_BITS-1:0] s_axi_control_ARADDR,
    output logic                     s_axi_control_RVALID,
    input  logic                     s_axi_control_RREADY,
    output logic [AXI_DATA_BITS-1:0] s_axi_control_RDATA,
    output logic [1:0]               s_axi_control_RRESP,
    output logic                     ap_start,
    input  logic                     ap_done,
    input  logic                     ap_idle,
    output logic [AXI_DATA_BITS-1:0] arg_a,
    output logic [AXI_DATA_BITS-1:0] arg_b,
    input  logic [AXI_DATA_BITS-1:0] result,
    input  logic                     result_vld
);

    localparam logic [AXI_ADDR_BITS-1:0] ADDR_CTRL   = AXI_ADDR_BITS'(8'h00);
    localparam logic [AXI_ADDR_BITS-1:0] ADDR_ARG_A  = AXI_ADDR_BITS'(8'h10);
    localparam logic [AXI_ADDR_BITS-1:0] ADDR_ARG_B  = AXI_ADDR_BITS'(8'h18);
    localparam logic [AXI_ADDR_BITS-1:0] ADDR_RESULT = AXI_ADDR_BITS'(8'h20);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    wstate_e                  wstate_q, wstate_d;
    rstate_e                  rstate_q, rstate_d;
    logic [AXI_ADDR_BITS-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_BITS-1:0] arg_a_q, arg_a_d;
    logic [AXI_DATA_BITS-1:0] arg_b_q, arg_b_d;
    logic [AXI_DATA_BITS-1:0] result_q, result_d;
    logic [AXI_DATA_BITS-1:0] rdata_q, rdata_d;
    logic [AXI_DATA_BITS-1:0] rd_mux;
    logic                     start_q, start_d;
    logic                     done_q, done_d;
    logic                     w_hs, ar_hs;

    function automatic logic [AXI_DATA_BITS-1:0] strb_merge(
        input logic [AXI_DATA_BITS-1:0] old_v,
        input logic [AXI_DATA_BITS-1:0] new_v,
        input logic [AXI_STRB_BITS-1:0] strb
    );
        logic [AXI_DATA_BITS-1:0] m;
        m = old_v;
        for (int b = 0; b < AXI_STRB_BITS; b++)
            if (strb[b]) m[b*8 +: 8] = new_v[b*8 +: 8];
        return m;
    endfunction

    assign w_hs  = (wstate_q == W_DATA) && s_axi_control_WVALID;
    assign ar_hs = (rstate_q == R_IDLE) && s_axi_control_ARVALID;

    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        case (wstate_q)
            W_IDLE: if (s_axi_control_AWVALID) begin
                wstate_d = W_DATA;
                awaddr_d = s_axi_control_AWADDR;
            end
            W_DATA: if (s_axi_control_WVALID) wstate_d = W_RESP;
            W_RESP: if (s_axi_control_BREADY) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Register file updates; unmapped and read-only targets simply fall through.
    always_comb begin
        arg_a_d  = arg_a_q;
        arg_b_d  = arg_b_q;
        start_d  = start_q;
        result_d = result_vld ? result : result_q;
        if (w_hs && awaddr_q == ADDR_ARG_A)
            arg_a_d = strb_merge(arg_a_q, s_axi_control_WDATA, s_axi_control_WSTRB);
        if (w_hs && awaddr_q == ADDR_ARG_B)
            arg_b_d = strb_merge(arg_b_q, s_axi_control_WDATA, s_axi_control_WSTRB);
        if (ap_done) start_d = 1'b0;
        // A start request on the same edge as ap_done must not be lost.
        if (w_hs && awaddr_q == ADDR_CTRL && s_axi_control_WSTRB[0] && s_axi_control_WDATA[0])
            start_d = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_control_ARADDR)
            ADDR_CTRL: begin
                rd_mux[0] = start_q;
                rd_mux[1] = done_q | ap_done;
                rd_mux[2] = ap_idle;
            end
            ADDR_ARG_A:  rd_mux = arg_a_q;
            ADDR_ARG_B:  rd_mux = arg_b_q;
            ADDR_RESULT: rd_mux = result_q;
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        done_d   = done_q | ap_done;
        case (rstate_q)
            R_IDLE: if (s_axi_control_ARVALID) begin
                rstate_d = R_DATA;
                rdata_d  = rd_mux;
            end
            R_DATA: if (s_axi_control_RREADY) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
        // The CTRL read already reported a coincident ap_done, so clearing is safe.
        if (ar_hs && s_axi_control_ARADDR == ADDR_CTRL) done_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            awaddr_q <= '0;
            arg_a_q  <= '0;
            arg_b_q  <= '0;
            result_q <= '0;
            rdata_q  <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            awaddr_q <= awaddr_d;
            arg_a_q  <= arg_a_d;
            arg_b_q  <= arg_b_d;
            result_q <= result_d;
            rdata_q  <= rdata_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign s_axi_control_AWREADY = (wstate_q == W_IDLE);
    assign s_axi_control_WREADY  = (wstate_q == W_DATA);
    assign s_axi_control_BVALID  = (wstate_q == W_RESP);
    assign s_axi_control_BRESP   = 2'b00;
    assign s_axi_control_ARREADY = (rstate_q == R_IDLE);
    assign s_axi_control_RVALID  = (rstate_q == R_DATA);
    assign s_axi_control_RDATA   = rdata_q;
    assign s_axi_control_RRESP   = 2'b00;
    assign ap_start              = start_q;
    assign arg_a                 = arg_a_q;
    assign arg_b                 = arg_b_q;

endmodule

// File: tb/tb_adder_ctrl_slave.sv
// Scoreboarded bench for adder_ctrl_slave: AXI-Lite reads push expected data,
// responses pop and compare; kernel handshakes checked directly.
module tb_adder_ctrl_slave;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [DW-1:0] wdata = '0, rdata;
    logic [3:0]    wstrb = '0;
    logic [1:0]    bresp, rresp;
    logic          ap_start, ap_done = 0, ap_idle = 0, result_vld = 0;
    logic [DW-1:0] arg_a, arg_b, result = '0;

    int            total = 0, bad = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    adder_ctrl_slave #(.AXI_ADDR_BITS(AW), .AXI_DATA_BITS(DW)) dut (
        .clock(clk), .reset(rst_n),
        .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready), .s_axi_control_AWADDR(awaddr),
        .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready),
        .s_axi_control_WDATA(wdata), .s_axi_control_WSTRB(wstrb),
        .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready), .s_axi_control_BRESP(bresp),
        .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready), .s_axi_control_ARADDR(araddr),
        .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
        .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .arg_a(arg_a), .arg_b(arg_b), .result(result), .result_vld(result_vld)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic aw_phase(input logic [AW-1:0] a);
        int n = 0;
        awvalid = 1; awaddr = a;
        while (!awready && n < TMO) begin tick(); n++; end
        if (n == TMO) chk("aw_timeout", 0, 1);
        tick();
        awvalid = 0;
    endtask

    task automatic w_phase(input logic [DW-1:0] d, input logic [3:0] s, input bit done_pulse);
        int n = 0;
        wvalid = 1; wdata = d; wstrb = s;
        while (!wready && n < TMO) begin tick(); n++; end
        if (n == TMO) chk("w_timeout", 0, 1);
        ap_done = done_pulse;
        tick();
        wvalid = 0; ap_done = 0;
    endtask

    task automatic b_phase();
        int n = 0;
        bready = 1;
        while (!bvalid && n < TMO) begin tick(); n++; end
        if (n == TMO) chk("b_timeout", 0, 1);
        chk("bresp", 32'(bresp), 0);
        tick();
        bready = 0;
        chk("bvalid_once", 32'(bvalid), 0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        aw_phase(a);
        w_phase(d, s, 1'b0);
        b_phase();
    endtask

    // side: 0 none, 1 ap_done pulse on AR edge, 2 result_vld pulse on AR edge
    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input int hold, input int side);
        int n = 0;
        logic [DW-1:0] got, exp_v;
        exp_q.push_back(e);
        arvalid = 1; araddr = a;
        while (!arready && n < TMO) begin tick(); n++; end
        if (n == TMO) chk("ar_timeout", 0, 1);
        ap_done = (side == 1);
        result_vld = (side == 2);
        tick();
        arvalid = 0; ap_done = 0; result_vld = 0;
        n = 0;
        while (!rvalid && n < TMO) begin tick(); n++; end
        if (n == TMO) chk("r_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            chk("rvalid_hold", 32'(rvalid), 1);
            chk("rdata_hold", rdata, exp_q[0]);
            tick();
        end
        got = rdata;
        chk("rresp", 32'(rresp), 0);
        rready = 1;
        tick();
        rready = 0;
        exp_v = exp_q.pop_front();
        chk("rdata", got, exp_v);
        chk("rvalid_drop", 32'(rvalid), 0);
    endtask

    initial begin
        #2;
        chk("rst_awready", 32'(awready), 1);
        chk("rst_arready", 32'(arready), 1);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_start", 32'(ap_start), 0);
        chk("rst_arg_a", arg_a, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        wr(6'h10, 32'h5, 4'hF);
        wr(6'h18, 32'h7, 4'hF);
        chk("arg_a_5", arg_a, 32'h5);
        chk("arg_b_7", arg_b, 32'h7);

        wr(6'h10, 32'hAABBCCDD, 4'hF);
        wr(6'h10, 32'h11223344, 4'h5);
        chk("arg_a_strb", arg_a, 32'hAA22CC44);
        rd(6'h10, 32'hAA22CC44, 0, 0);
        rd(6'h18, 32'h7, 0, 0);

        ap_idle = 1;
        wr(6'h00, 32'h1, 4'hF);
        chk("start_set", 32'(ap_start), 1);
        wr(6'h00, 32'h0, 4'hF);
        chk("start_sticky", 32'(ap_start), 1);
        ap_done = 1; tick(); ap_done = 0;
        chk("start_clr", 32'(ap_start), 0);
        rd(6'h00, 32'h6, 0, 0);
        rd(6'h00, 32'h4, 0, 0);
        rd(6'h00, 32'h6, 0, 1);
        rd(6'h00, 32'h4, 0, 0);

        ap_idle = 0;
        aw_phase(6'h00);
        w_phase(32'h1, 4'hF, 1'b1);
        chk("start_set_wins", 32'(ap_start), 1);
        b_phase();
        rd(6'h00, 32'h3, 0, 0);
        ap_done = 1; tick(); ap_done = 0;
        rd(6'h00, 32'h2, 0, 0);
        wr(6'h00, 32'h1, 4'h2);
        chk("start_strb0", 32'(ap_start), 0);

        result = 32'hC; result_vld = 1; tick(); result_vld = 0;
        rd(6'h20, 32'hC, 5, 0);
        rd(6'h3C, 32'h0, 0, 0);
        result = 32'h99;
        rd(6'h20, 32'hC, 0, 2);
        rd(6'h20, 32'h99, 0, 0);
        wr(6'h20, 32'h1234, 4'hF);
        rd(6'h20, 32'h99, 0, 0);
        wr(6'h3C, 32'hFFFFFFFF, 4'hF);
        chk("unmapped_a", arg_a, 32'hAA22CC44);
        chk("unmapped_b", arg_b, 32'h7);

        aw_phase(6'h18);
        chk("mid_wready", 32'(wready), 1);
        wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
        rst_n = 0;
        #1;
        chk("mid_rst_wready", 32'(wready), 0);
        chk("mid_rst_bvalid", 32'(bvalid), 0);
        chk("mid_rst_arg_b", arg_b, 32'h0);
        wvalid = 0;
        tick(); tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_awready", 32'(awready), 1);
            chk("post_rst_bvalid", 32'(bvalid), 0);
        end
        chk("post_rst_arg_b", arg_b, 32'h0);
        wr(6'h18, 32'h9, 4'hF);
        chk("post_rst_wr", arg_b, 32'h9);
        rd(6'h20, 32'h0, 0, 0);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
